// File: rtl/snax_hwpe_job_pkg.sv
// snax_hwpe_job_pkg: register map, FSM states and STATUS layout for the HWPE job register file
package snax_hwpe_job_pkg;
  localparam logic [5:0] WIDX_TRIGGER = 6'h00;
  localparam logic [5:0] WIDX_STATUS = 6'h01;
  localparam logic [5:0] WIDX_CLEAR = 6'h02;
  localparam logic [5:0] WIDX_JOBCNT = 6'h03;
  localparam logic [5:0] WIDX_CFG = 6'h10;
  localparam logic [31:0] RD_DEFAULT = 32'hDEAD_BEEF;
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;
  localparam int STATUS_CNT = 16;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RUN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
endpackage

// File: rtl/snax_hwpe_job_fsm.sv
// snax_hwpe_job_fsm: job launch/completion FSM with sticky done flag and completed-job counter
module snax_hwpe_job_fsm
  import snax_hwpe_job_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  input  logic        clear,
  input  logic        acc_done,
  output logic        busy,
  output logic        start,
  output logic        evt,
  output logic        done_sticky,
  output logic [31:0] job_cnt
);
  logic [1:0] state, state_d;
  always_comb
    state_d = (state == ST_IDLE && trigger) ? ST_START :
              (state == ST_START) ? ST_RUN :
              (state == ST_RUN && acc_done) ? ST_DONE :
              (state == ST_DONE) ? ST_IDLE : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      done_sticky <= 1'b0;
      job_cnt <= '0;
    end else begin
      state <= state_d;
      done_sticky <= evt | (done_sticky & ~clear);
      job_cnt <= job_cnt + 32'(evt);
    end
  assign busy = state == ST_START || state == ST_RUN;
  assign start = state == ST_START;
  assign evt = state == ST_DONE;
endmodule

// File: rtl/snax_hwpe_job_regfile.sv
// snax_hwpe_job_regfile: periph slave holding HWPE config registers and driving job start/completion
module snax_hwpe_job_regfile
  import snax_hwpe_job_pkg::*;
#(
  parameter int NumRegs = 8,
  parameter int IdWidth = 5,
  parameter int AddrWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   periph_req_i,
  output logic                   periph_gnt_o,
  input  logic [AddrWidth-1:0]   periph_add_i,
  input  logic                   periph_wen_i,
  input  logic [3:0]             periph_be_i,
  input  logic [31:0]            periph_data_i,
  input  logic [IdWidth-1:0]     periph_id_i,
  output logic [31:0]            periph_r_data_o,
  output logic                   periph_r_valid_o,
  output logic [IdWidth-1:0]     periph_r_id_o,
  output logic [NumRegs*32-1:0]  cfg_o,
  output logic                   start_o,
  input  logic                   acc_done_i,
  output logic                   busy_o,
  output logic                   evt_o
);
  logic [5:0] idx;
  logic wr, trigger, clear, done_sticky, unused_add;
  logic [31:0] job_cnt, status, rdata;
  logic [31:0] cfg_q [NumRegs];
  logic [NumRegs-1:0] cfg_we;
  assign periph_gnt_o = periph_req_i;
  assign idx = periph_add_i[7:2];
  assign unused_add = ^{periph_add_i[AddrWidth-1:8], periph_add_i[1:0]};
  assign wr = periph_req_i & ~periph_wen_i;
  assign trigger = wr & periph_be_i[0] & (idx == WIDX_TRIGGER);
  assign clear = wr & periph_be_i[0] & (idx == WIDX_CLEAR);
  snax_hwpe_job_fsm u_fsm (
    .clk        (clk_i),
    .rst        (rst_i),
    .trigger    (trigger),
    .clear      (clear),
    .acc_done   (acc_done_i),
    .busy       (busy_o),
    .start      (start_o),
    .evt        (evt_o),
    .done_sticky(done_sticky),
    .job_cnt    (job_cnt)
  );
  for (genvar r = 0; r < NumRegs; r++) begin : g_cfg
    assign cfg_we[r] = wr & ~busy_o & (idx == 6'(WIDX_CFG + r));
    assign cfg_o[32*r +: 32] = cfg_q[r];
    always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) cfg_q[r] <= '0;
      else for (int b = 0; b < 4; b++) if (cfg_we[r] && periph_be_i[b]) cfg_q[r][8*b +: 8] <= periph_data_i[8*b +: 8];
  end
  always_comb begin
    status = '0;
    status[STATUS_BUSY] = busy_o;
    status[STATUS_DONE] = done_sticky;
    status[STATUS_CNT +: 16] = job_cnt[15:0];
  end
  always_comb begin
    rdata = (idx == WIDX_TRIGGER || idx == WIDX_CLEAR) ? 32'h0 :
            (idx == WIDX_STATUS) ? status :
            (idx == WIDX_JOBCNT) ? job_cnt : RD_DEFAULT;
    for (int i = 0; i < NumRegs; i++) rdata = (idx == 6'(WIDX_CFG + i)) ? cfg_q[i] : rdata;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      periph_r_valid_o <= 1'b0;
      periph_r_id_o <= '0;
      periph_r_data_o <= '0;
    end else begin
      periph_r_valid_o <= periph_req_i;
      if (periph_req_i) begin
        periph_r_id_o <= periph_id_i;
        periph_r_data_o <= periph_wen_i ? rdata : 32'h0;
      end
    end
endmodule

// File: tb/tb_snax_hwpe_job_regfile.sv
// tb_snax_hwpe_job_regfile: randomized directed bench against a register-map level model
module tb_snax_hwpe_job_regfile;
  localparam int NR = 8;
  localparam int IW = 5;
  logic clk = 0, rst = 1, req = 0, wen = 0, acc_done = 0;
  logic gnt, r_valid, start, busy, evt;
  logic [31:0] add = 0, wdata = 0, r_data;
  logic [3:0] be = 0;
  logic [IW-1:0] id = 0, r_id;
  logic [NR*32-1:0] cfg;
  int vectors = 0, miscompares = 0;
  logic [31:0] cfg_m [NR];
  int phase = 0;
  logic sticky_m = 0;
  logic [31:0] cnt_m = 0;

  snax_hwpe_job_regfile #(.NumRegs(NR), .IdWidth(IW), .AddrWidth(32)) dut (
    .clk_i(clk), .rst_i(rst), .periph_req_i(req), .periph_gnt_o(gnt),
    .periph_add_i(add), .periph_wen_i(wen), .periph_be_i(be), .periph_data_i(wdata),
    .periph_id_i(id), .periph_r_data_o(r_data), .periph_r_valid_o(r_valid),
    .periph_r_id_o(r_id), .cfg_o(cfg), .start_o(start), .acc_done_i(acc_done),
    .busy_o(busy), .evt_o(evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_addr(input int w);
    return ($urandom & 32'hFFFF_FF03) | (32'(w) << 2);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    int w;
    w = int'(a[7:2]);
    if (w == 0 || w == 2) return 32'h0;
    if (w == 1) return {cnt_m[15:0], 14'h0, sticky_m, phase == 1};
    if (w == 3) return cnt_m;
    if (w >= 16 && w < 16 + NR) return cfg_m[w-16];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic void apply_write(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    int w;
    w = int'(a[7:2]);
    if (w >= 16 && w < 16 + NR && phase != 1)
      for (int k = 0; k < 4; k++) if (b[k]) cfg_m[w-16][8*k +: 8] = d[8*k +: 8];
    if (w == 0 && b[0] && phase == 0) phase = 1;
    if (w == 2 && b[0]) sticky_m = 0;
  endfunction

  function automatic void finish_job();
    phase = 0;
    sticky_m = 1;
    cnt_m = cnt_m + 1;
  endfunction

  task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d, input logic [IW-1:0] i);
    logic [31:0] exp;
    exp = w ? exp_rd(a) : 32'h0;
    if (!w) apply_write(a, b, d);
    req = 1; add = a; wen = w; be = b; wdata = d; id = i;
    #1 chk("gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    req = 0;
    chk("r_valid", 32'(r_valid), 32'h1);
    chk("r_id", 32'(r_id), 32'(i));
    chk(w ? "r_data_read" : "r_data_write", r_data, exp);
  endtask

  task automatic chk_cfg();
    for (int k = 0; k < NR; k++) chk($sformatf("cfg_o[%0d]", k), cfg[32*k +: 32], cfg_m[k]);
  endtask

  task automatic rd(input int w);
    xfer(mk_addr(w), 1'b1, 4'h0, $urandom, IW'($urandom));
  endtask

  initial begin
    for (int k = 0; k < NR; k++) cfg_m[k] = 0;
    repeat (2) @(negedge clk);
    chk("rst_r_valid", 32'(r_valid), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_evt", 32'(evt), 0);
    chk("rst_r_data", r_data, 0);
    chk_cfg();
    rst = 0;
    @(negedge clk);
    xfer(32'h40, 1'b0, 4'hF, 32'h1234_5678, 5'd5);
    xfer(32'h40, 1'b1, 4'h0, 32'h0, 5'd5);
    xfer(32'h44, 1'b0, 4'h5, 32'hAABB_CCDD, 5'd9);
    xfer(32'h44, 1'b1, 4'h0, 32'h0, 5'd10);
    xfer(32'h7C, 1'b1, 4'h0, 32'h0, 5'd11);
    rd(1);
    for (int n = 0; n < 60; n++) begin
      int w;
      logic rw;
      w = $urandom_range(1, 63);
      rw = 1'($urandom_range(0, 1));
      xfer(mk_addr(w), rw, 4'($urandom), $urandom, IW'($urandom));
    end
    chk_cfg();
    xfer(mk_addr(0), 1'b0, 4'h1, $urandom, 5'd1);
    chk("start_pulse", 32'(start), 1);
    chk("busy_start", 32'(busy), 1);
    acc_done = 1;
    @(negedge clk);
    acc_done = 0;
    chk("start_one_cycle", 32'(start), 0);
    chk("busy_run", 32'(busy), 1);
    chk("evt_ignored_in_start", 32'(evt), 0);
    xfer(mk_addr(16), 1'b0, 4'hF, 32'hFFFF_FFFF, 5'd2);
    xfer(mk_addr(16), 1'b1, 4'h0, 32'h0, 5'd3);
    xfer(mk_addr(0), 1'b0, 4'hF, $urandom, 5'd4);
    chk("no_restart_in_run", 32'(start), 0);
    repeat (3) @(negedge clk);
    chk("busy_hold", 32'(busy), 1);
    chk("evt_hold", 32'(evt), 0);
    acc_done = 1;
    rd(1);
    acc_done = 0;
    chk("evt_pulse", 32'(evt), 1);
    xfer(mk_addr(2), 1'b0, 4'h1, $urandom, 5'd6);
    finish_job();
    chk("evt_one_cycle", 32'(evt), 0);
    chk("busy_idle", 32'(busy), 0);
    xfer(32'h04, 1'b1, 4'h0, 32'h0, 5'd7);
    chk("status_after_job", r_data, 32'h0001_0002);
    xfer(32'h08, 1'b0, 4'h1, 32'h0, 5'd8);
    rd(1);
    rd(3);
    xfer(mk_addr(0), 1'b0, 4'h1, $urandom, 5'd12);
    repeat (2) @(negedge clk);
    acc_done = 1;
    @(negedge clk);
    acc_done = 0;
    chk("evt_job2", 32'(evt), 1);
    xfer(mk_addr(0), 1'b0, 4'h1, $urandom, 5'd13);
    finish_job();
    chk("trigger_in_done_busy", 32'(busy), 0);
    @(negedge clk);
    chk("trigger_in_done_start", 32'(start), 0);
    rd(1);
    rd(3);
    begin
      logic [31:0] pexp, nexp, a;
      nexp = 0;
      pexp = 0;
      for (int i = 0; i <= 32; i++) begin
        if (i < 32) begin
          a = mk_addr($urandom_range(0, 63));
          nexp = exp_rd(a);
          req = 1; add = a; wen = 1; id = IW'(i);
        end else req = 0;
        if (i > 0) begin
          chk("b2b_valid", 32'(r_valid), 1);
          chk("b2b_id", 32'(r_id), 32'(i - 1));
          chk("b2b_data", r_data, pexp);
        end
        pexp = nexp;
        @(negedge clk);
      end
      chk("b2b_end_valid", 32'(r_valid), 0);
    end
    xfer(mk_addr(0), 1'b0, 4'h1, $urandom, 5'd14);
    @(negedge clk);
    req = 1; add = mk_addr(16); wen = 1; id = 5'd15;
    @(posedge clk);
    #1 chk("pending_valid", 32'(r_valid), 1);
    rst = 1;
    req = 0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_start", 32'(start), 0);
    chk("arst_evt", 32'(evt), 0);
    chk("arst_r_valid", 32'(r_valid), 0);
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < NR; k++) cfg_m[k] = 0;
    phase = 0;
    sticky_m = 0;
    cnt_m = 0;
    chk_cfg();
    xfer(32'h40, 1'b1, 4'h0, 32'h0, 5'd16);
    rd(1);
    rd(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/snax_hwpe_job_regfile.md
Name: snax_hwpe_job_regfile

Overview:
- Peripheral-side slave that sits directly downstream of the Snitch-to-HWPE control bridge.
- Consumes its 32-bit periph request stream and returns one read response per granted request.
- Holds the accelerator configuration registers and runs the job launch/completion state machine.
- Drives the accelerator datapath with a config bus, a start pulse, and a completion event back to the core.

Parameters:
- NumRegs, 8, number of generic 32-bit config registers (1..32)
- IdWidth, 5, width of the periph transaction ID
- AddrWidth, 32, width of the periph address bus (only bits [7:2] decoded)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- periph_req_i  in  1  request valid
- periph_gnt_o  out  1  request granted
- periph_add_i  in  AddrWidth  byte address
- periph_wen_i  in  1  1 = read, 0 = write
- periph_be_i  in  4  byte enables for writes
- periph_data_i  in  32  write data
- periph_id_i  in  IdWidth  transaction ID
- periph_r_data_o  out  32  read data
- periph_r_valid_o  out  1  response valid
- periph_r_id_o  out  IdWidth  echoed ID
- cfg_o  out  NumRegs*32  live config register contents
- start_o  out  1  one-cycle job launch pulse
- acc_done_i  in  1  accelerator finished current job (pulse)
- busy_o  out  1  job in flight
- evt_o  out  1  one-cycle completion event

Behaviour:
- Reset (async, rst_i=1): all outputs 0; config regs 0; FSM IDLE; job counter 0.
- Grant: periph_gnt_o = periph_req_i, combinational, never stalls.
- Response timing: exactly one response per granted request, for writes too.
  - periph_r_valid_o = 1 in the cycle after the grant.
  - r_id echoes the granted ID.
  - Writes return r_data = 0.
- Register map, word index = add[7:2]:
  - 0x00 TRIGGER (W): with be[0]=1 and FSM IDLE, move to START. Ignored otherwise. Reads 0.
  - 0x04 STATUS (R): bit0 busy_o, bit1 done_sticky, bits[31:16] job counter. Writes ignored.
  - 0x08 CLEAR (W): with be[0]=1, clear done_sticky. Reads 0.
  - 0x0C JOBCNT (R): full 32-bit completed-job counter, wraps 0xFFFFFFFF -> 0.
  - 0x40 + 4*i, i < NumRegs: config reg i, R/W. Writes honour be per byte.
  - Any other address: reads return 0xDEADBEEF, writes have no effect; response still given.
- Config write protection: config-reg writes while busy_o=1 are dropped, but the response is still returned.
- FSM:
  - IDLE: busy_o=0.
  - START: start_o=1 for exactly one cycle; busy_o=1; go to RUN.
  - RUN: busy_o=1; on acc_done_i go to DONE.
  - DONE: evt_o=1 for one cycle; set done_sticky; increment counter; return to IDLE.
- Boundaries:
  - acc_done_i outside RUN is ignored, including in the START cycle.
  - TRIGGER and CLEAR in the same cycle cannot occur (single port).
  - CLEAR in the DONE cycle: the set wins.
  - TRIGGER in the DONE cycle is ignored; software must poll STATUS.
  - Read of STATUS in the cycle a transition happens returns the pre-transition (registered) value.
  - Reset mid-RUN: FSM returns to IDLE immediately; any pending response is dropped; r_valid=0.

Decomposition:
- Package snax_hwpe_job_pkg:
  - register offset constants
  - FSM state enum (IDLE, START, RUN, DONE)
  - DEADBEEF default constant
  - STATUS bit positions
- Sub-module snax_hwpe_job_fsm: FSM, done_sticky and job counter.
- Register decode/response pipeline stays in the top.

Test Plan:
- Reset then write 0x12345678 to 0x40 with be=0xF, read 0x40 -> response 1 cycle after each grant, read data 0x12345678, r_id echoes the ID (e.g. 5).
- Write 0xAABBCCDD to 0x44 with be=0x5 after reset -> read 0x44 returns 0x00BB00DD.
- Write TRIGGER -> start_o high exactly 1 cycle, busy_o=1. Write 0xFFFFFFFF to 0x40 while busy -> read 0x40 unchanged. acc_done_i pulse -> evt_o 1 cycle later, STATUS = 0x00010002.
- Second TRIGGER while RUN -> no start_o pulse. After done, CLEAR -> STATUS bit1 = 0, JOBCNT = 1.
- Read 0x7C with NumRegs=8 -> 0xDEADBEEF. Back-to-back reads every cycle with IDs 0..31 -> 32 responses, IDs in order, no gaps.
- Assert rst_i during RUN -> busy_o, start_o, evt_o and r_valid drop to 0 asynchronously; 0x40 reads 0 after reset.
